// File: rtl/dds_phase_to_amplitude.sv
// Phase-to-amplitude converter for a DDS: quarter-wave sine ROM with quadrant
// folding plus square/sawtooth/triangle, all aligned by a 3-stage valid pipeline.
module dds_phase_to_amplitude #(
   parameter int PW = 14,
   parameter int AW = 8,
   parameter int QB = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [PW-1:0] phase,
   input  logic          phase_valid,
   input  logic [1:0]    wave_sel,
   output logic [AW-1:0] amp,
   output logic          amp_valid
);

   typedef enum logic [1:0] {
      WAVE_SINE   = 2'd0,
      WAVE_SQUARE = 2'd1,
      WAVE_SAW    = 2'd2,
      WAVE_TRI    = 2'd3
   } wave_t;

   localparam int            ROM_DEPTH = 2 ** QB;
   localparam logic [AW-1:0] MID       = {1'b1, {(AW-1){1'b0}}};
   localparam logic [AW-1:0] MID_M1    = MID - 1'b1;

   // Elaboration-time sine in 2^30 fixed point (Taylor series to x^17), rounded
   // to AW-1 bits. Evaluated at (k+0.5) so ~idx mirroring lands on exact entries.
   function automatic int rom_entry(input int k);
      longint scale;
      longint pi_fix;
      longint x;
      longint term;
      longint acc;
      scale  = 64'sd1 <<< 30;
      pi_fix = 64'sd3373259426;
      x      = (pi_fix * longint'(2 * k + 1)) / longint'(4 * ROM_DEPTH);
      term   = x;
      acc    = x;
      for (int n = 1; n <= 8; n++) begin
         term = -((((term * x) / scale) * x) / scale) / longint'((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      return int'((longint'(2 ** (AW - 1) - 1) * acc + scale / 2) / scale);
   endfunction

   logic [AW-2:0] rom [ROM_DEPTH];

   for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
      localparam int ENTRY = rom_entry(k);
      assign rom[k] = ENTRY[AW-2:0];
   end

   // Low phase bits below the sine index / triangle slice carry no information here.
   logic unused_phase;
   assign unused_phase = ^phase;

   // Stage 1: capture (only the top AW+1 phase bits are needed downstream)
   logic          v1;
   logic [AW:0]   ph1;
   logic [QB-1:0] midx1;
   wave_t         sel1;

   // Stage 2: lookup
   logic          v2;
   logic [AW:0]   ph2;
   logic [AW-2:0] q2;
   wave_t         sel2;

   logic [AW-1:0] shaped;

   // NOTE: only the valid bits and the output register are reset; the data
   // registers are don't-care while their valid bit is low, so they stay reset-free.
   always_ff @(posedge clk) begin
      if (phase_valid) begin
         ph1   <= phase[PW-1 -: AW+1];
         midx1 <= phase[PW-2] ? ~phase[PW-3 -: QB] : phase[PW-3 -: QB];
         sel1  <= wave_t'(wave_sel);
      end
      ph2  <= ph1;
      q2   <= rom[midx1];
      sel2 <= sel1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         amp_valid <= 1'b0;
         amp       <= MID;
      end else begin
         v1        <= phase_valid;
         v2        <= v1;
         amp_valid <= v2;
         if (v2) begin
            amp <= shaped;
         end
      end
   end

   // Stage 3 shaping; ph2[AW] is the half-cycle bit, ph2[AW-1] the quarter bit.
   always_comb begin
      shaped = MID;
      case (sel2)
         WAVE_SINE:   shaped = ph2[AW] ? (MID_M1 - {1'b0, q2}) : (MID + {1'b0, q2});
         WAVE_SQUARE: shaped = {AW{~ph2[AW]}};
         WAVE_SAW:    shaped = ph2[AW:1];
         WAVE_TRI:    shaped = ph2[AW] ? ~ph2[AW-1:0] : ph2[AW-1:0];
         default:     shaped = MID;
      endcase
   end

endmodule

// File: tb/tb_dds_phase_to_amplitude.sv
// Self-checking bench for dds_phase_to_amplitude: directed steps plus random
// stimulus checked against a full-wave arithmetic model and a latency scoreboard.
module tb_dds_phase_to_amplitude;

   localparam real PI = 3.14159265358979323846;

   logic        clk;
   logic        rst;
   logic [13:0] phase;
   logic        phase_valid;
   logic [1:0]  wave_sel;
   logic [7:0]  amp;
   logic        amp_valid;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   typedef struct {
      logic        v;
      int          amp;
      logic [13:0] ph;
      logic [1:0]  sel;
   } entry_t;

   entry_t q[$];
   int     exp_amp   = 128;
   int     exp_valid = 0;
   int     dut_sine [16384];

   dds_phase_to_amplitude #(.PW(14), .AW(8), .QB(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .phase       (phase),
      .phase_valid (phase_valid),
      .wave_sel    (wave_sel),
      .amp         (amp),
      .amp_valid   (amp_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-cycle sine over 256 points per cycle, offset-binary with the
   // negative half sitting one code below midscale; other waves from plain arithmetic.
   function automatic int ref_amp(input logic [13:0] ph, input logic [1:0] sel);
      int  n;
      int  r;
      int  t;
      real s;
      n = int'(ph) / 64;
      t = (int'(ph) / 32) % 256;
      case (sel)
         2'd0: begin
            s = 127.0 * $sin(2.0 * PI * (real'(n) + 0.5) / 256.0);
            r = (s >= 0.0) ? $rtoi($floor(s + 0.5)) : -$rtoi($floor(-s + 0.5));
            return (s >= 0.0) ? 128 + r : 127 + r;
         end
         2'd1:    return (int'(ph) < 8192) ? 255 : 0;
         2'd2:    return n;
         default: return (int'(ph) < 8192) ? t : 255 - t;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      checks++;
      assert (obs === expd) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
      end
   endtask

   // One clock of stimulus; lit >= 0 overrides the model with a literal expectation.
   task automatic cycle(input logic r, input logic v, input logic [13:0] ph,
                        input logic [1:0] sel, input int lit);
      entry_t e;
      rst         = r;
      phase_valid = v;
      phase       = ph;
      wave_sel    = sel;
      @(posedge clk);
      @(negedge clk);
      if (r) begin
         q.delete();
         exp_amp   = 128;
         exp_valid = 0;
      end else begin
         e.v   = v;
         e.amp = (lit >= 0) ? lit : ref_amp(ph, sel);
         e.ph  = ph;
         e.sel = sel;
         q.push_back(e);
         exp_valid = 0;
         if (q.size() == 3) begin
            e = q.pop_front();
            exp_valid = int'(e.v);
            if (e.v) begin
               exp_amp = e.amp;
               if (e.sel == 2'd0) dut_sine[e.ph] = int'(amp);
            end
         end
      end
      check("amp_valid", {31'd0, amp_valid}, exp_valid);
      check("amp", {24'd0, amp}, exp_amp);
   endtask

   initial begin
      int d;
      foreach (dut_sine[i]) dut_sine[i] = -1;

      // Reset held for 2 cycles with phase_valid high
      cycle(1'b1, 1'b1, 14'h0000, 2'd0, -1);
      cycle(1'b1, 1'b1, 14'h0000, 2'd0, -1);

      // Sine quadrants back-to-back; first valid appears on the third cycle
      cycle(1'b0, 1'b1, 14'h0000, 2'd0, 8'h82);
      cycle(1'b0, 1'b1, 14'h1000, 2'd0, 8'hFF);
      cycle(1'b0, 1'b1, 14'h2000, 2'd0, 8'h7D);
      cycle(1'b0, 1'b1, 14'h3000, 2'd0, 8'h00);

      // Derived waves
      cycle(1'b0, 1'b1, 14'h1234, 2'd2, 8'h48);
      cycle(1'b0, 1'b1, 14'h1234, 2'd3, 8'h91);
      cycle(1'b0, 1'b1, 14'h1234, 2'd1, 8'hFF);
      cycle(1'b0, 1'b1, 14'h2000, 2'd1, 8'h00);

      // Bubble pattern 1,0,1,1,0 then drain
      cycle(1'b0, 1'b1, 14'h0400, 2'd0, -1);
      cycle(1'b0, 1'b0, 14'h3FFF, 2'd2, -1);
      cycle(1'b0, 1'b1, 14'h2A00, 2'd0, -1);
      cycle(1'b0, 1'b1, 14'h1555, 2'd3, -1);
      cycle(1'b0, 1'b0, 14'h0001, 2'd1, -1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 14'h0000, 2'd0, -1);

      // wave_sel switch mid-stream: sine samples stay sine, square follows
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 14'h0800, 2'd0, -1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 14'h0800, 2'd1, -1);

      // Reset with 3 valid samples in flight; sample coinciding with rst is dropped
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 14'h0C00, 2'd2, -1);
      cycle(1'b1, 1'b1, 14'h3000, 2'd3, -1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 14'h0000, 2'd0, -1);

      // Full sine sweep with wrap-around, then drain
      for (int p = 0; p < 16384; p++) cycle(1'b0, 1'b1, 14'(p), 2'd0, -1);
      for (int p = 0; p < 4; p++) cycle(1'b0, 1'b1, 14'(p), 2'd0, -1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 14'h0000, 2'd0, -1);

      // Half-cycle antisymmetry and continuity across the peaks
      for (int p = 0; p < 8192; p += 64) begin
         check("sine_sym", dut_sine[p] + dut_sine[p + 8192], 255);
      end
      d = dut_sine[14'h1000] - dut_sine[14'h0FC0];
      check("peak_step_q01", (d <= 1 && d >= -1) ? 1 : 0, 1);
      d = dut_sine[14'h3000] - dut_sine[14'h2FC0];
      check("peak_step_q23", (d <= 1 && d >= -1) ? 1 : 0, 1);
      check("peak_q0_end", dut_sine[14'h0FFF], 255);
      check("peak_q1_start", dut_sine[14'h1000], 255);

      // Randomized phase, waveform and bubbles
      for (int i = 0; i < 500; i++) begin
         cycle(1'b0, ($urandom_range(0, 3) != 0), 14'($urandom), 2'($urandom), -1);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 14'h0000, 2'd0, -1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
